// File: rtl/synth_pkg.sv
// Shared types and constants for the wave shaper: waveform selection, FSM
// states, mid-scale level and the number of phase bits resolved per sample.
package synth_pkg;

    typedef enum logic [1:0] {
        SQUARE   = 2'b00,
        SAW      = 2'b01,
        TRIANGLE = 2'b10,
        MUTE     = 2'b11
    } wave_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } shaper_state_t;

    localparam logic [7:0] MIDSCALE    = 8'd128;
    localparam int         PHASE_STEPS = 8;

endpackage

// File: rtl/phase_divider.sv
// Iterative restoring divider producing the oscillator phase
// floor((count-1) * 2^STEPS / divider), one quotient bit per clock.
module phase_divider
    import synth_pkg::*;
#(
    parameter int STEPS = PHASE_STEPS
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      dividend,
    input  logic [15:0]      divisor,
    output logic             done,
    output logic [STEPS-1:0] quotient
);

    localparam int CNT_W = $clog2(STEPS + 1);

    logic [16:0]      rem;
    logic [15:0]      div_q;
    logic [STEPS-1:0] quo;
    logic [CNT_W-1:0] step;
    logic             active;
    logic             sat;

    logic [16:0]      rem_start;
    logic [16:0]      rem_shift;
    logic             start_sat;
    logic             fits;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rem_start = '0;
        start_sat = 1'b0;
        if (divisor != 16'd0) begin
            if (dividend == 16'd0 || dividend > divisor) begin
                rem_start = {1'b0, divisor - 16'd1};
                start_sat = 1'b1;
            end else begin
                rem_start = {1'b0, dividend - 16'd1};
            end
        end
        rem_shift = rem << 1;
        // A zero divisor never subtracts, so the quotient stays all zeros.
        fits = (div_q != 16'd0) && (rem_shift >= {1'b0, div_q});
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rem    <= '0;
            div_q  <= '0;
            quo    <= '0;
            step   <= '0;
            active <= 1'b0;
            sat    <= 1'b0;
        end else if (start) begin
            rem    <= rem_start;
            div_q  <= divisor;
            quo    <= '0;
            step   <= '0;
            active <= 1'b1;
            sat    <= start_sat;
        end else if (abort) begin
            active <= 1'b0;
        end else if (active) begin
            rem  <= fits ? (rem_shift - {1'b0, div_q}) : rem_shift;
            quo  <= {quo[STEPS-2:0], fits};
            step <= step + 1'b1;
            if (step == CNT_W'(STEPS - 1)) begin
                active <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge retires the final quotient bit.
    assign done     = active && !abort && (step == CNT_W'(STEPS - 1));
    // Out-of-range counts pin the phase to full scale.
    assign quotient = sat ? '1 : quo;

endmodule

// File: rtl/wave_shaper.sv
// Waveform shaper: captures an oscillator position, derives its phase with
// phase_divider and registers a square/saw/triangle/mute sample from it.
module wave_shaper
    import synth_pkg::*;
#(
    parameter int SAMPLE_W    = 8,
    parameter int PHASE_STEPS = synth_pkg::PHASE_STEPS
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [15:0]         count,
    input  logic [15:0]         divider,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIDSCALE);

    shaper_state_t          state;
    shaper_state_t          next_state;
    wave_mode_t             mode_q;
    logic                   start;
    logic                   abort;
    logic                   div_done;
    logic [PHASE_STEPS-1:0] phase;

    function automatic logic [SAMPLE_W-1:0] shape(input wave_mode_t m,
                                                  input logic [SAMPLE_W-1:0] p);
        logic [SAMPLE_W-1:0] r;
        r = MID;
        case (m)
            SQUARE:   r = p[SAMPLE_W-1] ? '0 : '1;
            SAW:      r = p;
            // Upper half folds back: ~p is (full-scale - p).
            TRIANGLE: r = p[SAMPLE_W-1] ? ((~p) << 1) : (p << 1);
            MUTE:     r = MID;
            default:  r = MID;
        endcase
        return r;
    endfunction

    phase_divider #(
        .STEPS(PHASE_STEPS)
    ) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .abort    (abort),
        .dividend (count),
        .divisor  (divider),
        .done     (div_done),
        .quotient (phase)
    );

    always_comb begin
        next_state = state;
        start      = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    start      = 1'b1;
                    next_state = DIV;
                end
            end
            DIV: begin
                if (!en) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (div_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                abort      = !en;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample       <= MID;
            sample_valid <= 1'b0;
            mode_q       <= MUTE;
        end else begin
            sample_valid <= 1'b0;
            if (start) begin
                mode_q <= wave_mode_t'(mode);
            end
            if (abort) begin
                sample <= MID;
            end else if (state == DONE) begin
                sample       <= shape(mode_q, SAMPLE_W'(phase));
                sample_valid <= 1'b1;
            end
        end
    end

endmodule
